// File: rtl/pc_next_seq_if.sv
// Request/response bundle between fetch-decode control and the next-PC generator.
// The control side (master) drives the PC and redirect requests; the generator
// (slave) returns the next PC, squash flag and return-stack status.
interface pc_next_seq_if #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned RAS_DEPTH = 4
);
  localparam int unsigned DW = $clog2(RAS_DEPTH) + 1;

  logic [WIDTH-1:0] current;
  logic             stall;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_offset;
  logic             jump;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] jump_target;
  logic [WIDTH-1:0] next;
  logic             flush;
  logic [DW-1:0]    ras_depth;
  logic             ras_overflow;
  logic             ras_underflow;

  modport master (
    output current, stall, branch_taken, branch_offset, jump, call, ret, jump_target,
    input  next, flush, ras_depth, ras_overflow, ras_underflow
  );

  modport slave (
    input  current, stall, branch_taken, branch_offset, jump, call, ret, jump_target,
    output next, flush, ras_depth, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_next_seq.sv
// Next-PC generator with return-address stack and post-redirect squash FSM.
// Latency: next is combinational from current/requests; flush and RAS flags are registered.
// Backpressure: stall holds the PC (next=current) and freezes every internal register.
module pc_next_seq #(
  parameter int unsigned          WIDTH        = 16,
  parameter int unsigned          INC          = 4,
  parameter logic [WIDTH-1:0]     RESET_PC     = '0,
  parameter int unsigned          RAS_DEPTH    = 4,
  parameter int unsigned          FLUSH_CYCLES = 2
) (
  input  logic         clock,
  input  logic         reset,
  pc_next_seq_if.slave bus
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned DW = PW + 1;
  localparam int unsigned CW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             flush_q, flush_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_d [RAS_DEPTH];
  logic [PW-1:0]    wp_q, wp_d;      // next free slot; top of stack is wp_q-1
  logic [DW-1:0]    depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] top_pc;
  logic [WIDTH-1:0] next_pc;
  logic             redirect;

  assign seq_pc = bus.current + WIDTH'(INC);
  assign top_pc = ras_q[wp_q - PW'(1)];

  // Request arbitration (ret > call > jump > branch > sequential) and next-state computation.
  // A ret on an empty stack keeps the sequential path, so it is not treated as a redirect.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    flush_d  = flush_q;
    ras_d    = ras_q;
    wp_d     = wp_q;
    depth_d  = depth_q;
    ovf_d    = ovf_q;
    unf_d    = 1'b0;
    next_pc  = seq_pc;
    redirect = 1'b0;

    if (bus.stall) begin
      next_pc = bus.current;
    end else if (state_q == S_RUN) begin
      if (bus.ret) begin
        if (depth_q != '0) begin
          next_pc  = top_pc;
          wp_d     = wp_q - PW'(1);
          depth_d  = depth_q - DW'(1);
          redirect = 1'b1;
        end else begin
          unf_d = 1'b1;
        end
      end else if (bus.call) begin
        next_pc     = bus.jump_target;
        ras_d[wp_q] = seq_pc;          // when full this overwrites the oldest entry
        wp_d        = wp_q + PW'(1);
        if (depth_q == DW'(RAS_DEPTH)) begin
          ovf_d = 1'b1;
        end else begin
          depth_d = depth_q + DW'(1);
        end
        redirect = 1'b1;
      end else if (bus.jump) begin
        next_pc  = bus.jump_target;
        redirect = 1'b1;
      end else if (bus.branch_taken) begin
        next_pc  = bus.current + bus.branch_offset;
        redirect = 1'b1;
      end

      if (redirect) begin
        state_d = S_FLUSH;
        cnt_d   = CW'(FLUSH_CYCLES);
        flush_d = 1'b1;
      end
    end else begin
      // Squash window: requests belong to wrong-path instructions and are ignored.
      if (cnt_q == CW'(1)) begin
        state_d = S_RUN;
        cnt_d   = '0;
        flush_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // State registers with synchronous active-low reset; reset empties the stack.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      ras_q   <= '{default: '0};
      wp_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      ras_q   <= ras_d;
      wp_q    <= wp_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.next          = reset ? next_pc : RESET_PC;
  assign bus.flush         = flush_q;
  assign bus.ras_depth     = depth_q;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_next_seq.sv
// Bench for pc_next_seq: directed scenarios plus randomized traffic,
// all checked against a queue-based model of the PC/return-stack rules.
module tb_pc_next_seq;

  logic clock = 1'b0;
  logic reset = 1'b0;

  int total  = 0;
  int passed = 0;

  pc_next_seq_if #(.WIDTH(16), .RAS_DEPTH(4)) bus ();

  pc_next_seq #(
    .WIDTH(16), .INC(4), .RESET_PC(16'h0000), .RAS_DEPTH(4), .FLUSH_CYCLES(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  // Reference model state: stack as a queue (back = top), remaining squash cycles, flags.
  logic [15:0] m_ras[$];
  int          m_flush = 0;
  bit          m_ovf   = 1'b0;
  bit          m_unf   = 1'b0;

  function automatic logic [15:0] model_next();
    logic [15:0] seq;
    seq = bus.current + 16'd4;
    if (!reset)                 return 16'h0000;
    if (bus.stall)              return bus.current;
    if (m_flush > 0)            return seq;
    if (bus.ret)                return (m_ras.size() > 0) ? m_ras[$] : seq;
    if (bus.call || bus.jump)   return bus.jump_target;
    if (bus.branch_taken)       return bus.current + bus.branch_offset;
    return seq;
  endfunction

  function automatic void model_commit();
    bit redir;
    redir = 1'b0;
    if (!reset) begin
      m_ras.delete();
      m_flush = 0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      return;
    end
    m_unf = 1'b0;
    if (bus.stall) return;
    if (m_flush > 0) begin
      m_flush--;
      return;
    end
    if (bus.ret) begin
      if (m_ras.size() > 0) begin
        void'(m_ras.pop_back());
        redir = 1'b1;
      end else begin
        m_unf = 1'b1;
      end
    end else if (bus.call) begin
      m_ras.push_back(bus.current + 16'd4);
      if (m_ras.size() > 4) begin
        void'(m_ras.pop_front());
        m_ovf = 1'b1;
      end
      redir = 1'b1;
    end else if (bus.jump || bus.branch_taken) begin
      redir = 1'b1;
    end
    if (redir) m_flush = 2;
  endfunction

  task automatic step();
    @(posedge clock);
    model_commit();
    #1;
  endtask

  task automatic clear_req();
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_offset = 16'h0000;
    bus.jump          = 1'b0;
    bus.call          = 1'b0;
    bus.ret           = 1'b0;
    bus.jump_target   = 16'h0000;
  endtask

  task automatic drain();
    clear_req();
    repeat (2) step();
  endtask

  task automatic test_reset();
    clear_req();
    reset       = 1'b0;
    bus.current = 16'h0040;
    #1;
    total++;
    if (bus.next !== 16'h0000) $display("FAIL reset_next: got %h want 0000", bus.next);
    else passed++;
    step();
    step();
    total++;
    if (bus.flush !== 1'b0 || bus.ras_depth !== 3'd0 || bus.ras_overflow !== 1'b0 || bus.ras_underflow !== 1'b0)
      $display("FAIL reset_state: flush=%b depth=%0d ovf=%b unf=%b want 0/0/0/0",
               bus.flush, bus.ras_depth, bus.ras_overflow, bus.ras_underflow);
    else passed++;
    reset       = 1'b1;
    bus.current = 16'h0000;
    #1;
    total++;
    if (bus.next !== 16'h0004) $display("FAIL release_next: got %h want 0004", bus.next);
    else passed++;
    step();
  endtask

  task automatic test_branch();
    clear_req();
    bus.current       = 16'h0100;
    bus.branch_taken  = 1'b1;
    bus.branch_offset = 16'hFFF0;
    #1;
    total++;
    if (bus.next !== 16'h00F0) $display("FAIL branch_next: got %h want 00F0", bus.next);
    else passed++;
    step();
    for (int i = 0; i < 2; i++) begin
      bus.current       = 16'h00F0 + 16'(i * 4);
      bus.branch_offset = 16'h0100;
      #1;
      total++;
      if (bus.flush !== 1'b1 || bus.next !== bus.current + 16'd4)
        $display("FAIL branch_squash%0d: flush=%b next=%h want 1/%h", i, bus.flush, bus.next, bus.current + 16'd4);
      else passed++;
      step();
    end
    total++;
    if (bus.flush !== 1'b0) $display("FAIL branch_flush_end: got %b want 0", bus.flush);
    else passed++;
  endtask

  task automatic test_call_ret();
    clear_req();
    bus.current     = 16'h0200;
    bus.call        = 1'b1;
    bus.jump_target = 16'h0800;
    #1;
    total++;
    if (bus.next !== 16'h0800) $display("FAIL call_next: got %h want 0800", bus.next);
    else passed++;
    step();
    total++;
    if (bus.ras_depth !== 3'd1) $display("FAIL call_depth: got %0d want 1", bus.ras_depth);
    else passed++;
    drain();
    bus.current = 16'h0810;
    bus.ret     = 1'b1;
    #1;
    total++;
    if (bus.next !== 16'h0204) $display("FAIL ret_next: got %h want 0204", bus.next);
    else passed++;
    step();
    total++;
    if (bus.ras_depth !== 3'd0) $display("FAIL ret_depth: got %0d want 0", bus.ras_depth);
    else passed++;
    drain();
  endtask

  task automatic test_overflow();
    logic [15:0] want;
    for (int i = 0; i < 5; i++) begin
      clear_req();
      bus.current     = 16'h1000 + 16'(i * 16'h0100);
      bus.call        = 1'b1;
      bus.jump_target = 16'h4000 + 16'(i * 16'h0010);
      step();
      drain();
    end
    total++;
    if (bus.ras_depth !== 3'd4 || bus.ras_overflow !== 1'b1)
      $display("FAIL overflow: depth=%0d ovf=%b want 4/1", bus.ras_depth, bus.ras_overflow);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      clear_req();
      bus.current = 16'h2000;
      bus.ret     = 1'b1;
      want        = 16'h1404 - 16'(i * 16'h0100);
      #1;
      total++;
      if (bus.next !== want) $display("FAIL lifo_ret%0d: got %h want %h", i, bus.next, want);
      else passed++;
      step();
      drain();
    end
    clear_req();
    bus.current = 16'h3000;
    bus.ret     = 1'b1;
    #1;
    total++;
    if (bus.next !== 16'h3004) $display("FAIL underflow_next: got %h want 3004", bus.next);
    else passed++;
    step();
    total++;
    if (bus.ras_underflow !== 1'b1 || bus.ras_depth !== 3'd0)
      $display("FAIL underflow_pulse: unf=%b depth=%0d want 1/0", bus.ras_underflow, bus.ras_depth);
    else passed++;
    clear_req();
    step();
    total++;
    if (bus.ras_underflow !== 1'b0) $display("FAIL underflow_clear: got %b want 0", bus.ras_underflow);
    else passed++;
  endtask

  task automatic test_wrap_stall();
    clear_req();
    bus.current = 16'hFFFC;
    #1;
    total++;
    if (bus.next !== 16'h0000) $display("FAIL wrap_next: got %h want 0000", bus.next);
    else passed++;
    step();
    bus.current     = 16'h0500;
    bus.stall       = 1'b1;
    bus.jump        = 1'b1;
    bus.jump_target = 16'h1234;
    #1;
    total++;
    if (bus.next !== 16'h0500) $display("FAIL stall_next: got %h want 0500", bus.next);
    else passed++;
    step();
    total++;
    if (bus.flush !== 1'b0 || bus.ras_depth !== 3'(m_ras.size()))
      $display("FAIL stall_state: flush=%b depth=%0d want 0/%0d", bus.flush, bus.ras_depth, m_ras.size());
    else passed++;
    clear_req();
  endtask

  task automatic test_reset_mid_flush();
    for (int i = 0; i < 2; i++) begin
      clear_req();
      bus.current     = 16'h0600 + 16'(i * 16'h0040);
      bus.call        = 1'b1;
      bus.jump_target = 16'h0A00;
      step();
      drain();
    end
    bus.current     = 16'h0A10;
    bus.jump        = 1'b1;
    bus.jump_target = 16'h0C00;
    step();
    clear_req();
    total++;
    if (bus.flush !== 1'b1 || bus.ras_depth !== 3'd2)
      $display("FAIL pre_reset: flush=%b depth=%0d want 1/2", bus.flush, bus.ras_depth);
    else passed++;
    reset = 1'b0;
    #1;
    total++;
    if (bus.next !== 16'h0000) $display("FAIL midflush_next: got %h want 0000", bus.next);
    else passed++;
    step();
    total++;
    if (bus.flush !== 1'b0 || bus.ras_depth !== 3'd0 || bus.ras_overflow !== 1'b0)
      $display("FAIL midflush_reset: flush=%b depth=%0d ovf=%b want 0/0/0",
               bus.flush, bus.ras_depth, bus.ras_overflow);
    else passed++;
    reset = 1'b1;
  endtask

  task automatic test_random();
    logic [15:0] exp_next;
    logic [15:0] prev;
    prev = 16'h0000;
    for (int i = 0; i < 600; i++) begin
      reset             = ($urandom_range(0, 49) != 0);
      bus.stall         = ($urandom_range(0, 4) == 0);
      bus.ret           = ($urandom_range(0, 4) == 0);
      bus.call          = ($urandom_range(0, 3) == 0);
      bus.jump          = ($urandom_range(0, 5) == 0);
      bus.branch_taken  = ($urandom_range(0, 4) == 0);
      bus.jump_target   = 16'($urandom);
      bus.branch_offset = 16'($urandom);
      bus.current       = ($urandom_range(0, 7) == 0) ? 16'($urandom) : prev;
      #1;
      exp_next = model_next();
      total++;
      if (bus.next !== exp_next) $display("FAIL rand_next[%0d]: got %h want %h", i, bus.next, exp_next);
      else passed++;
      prev = exp_next;
      step();
      total++;
      if (bus.flush !== (m_flush > 0) || bus.ras_depth !== 3'(m_ras.size()) ||
          bus.ras_overflow !== m_ovf || bus.ras_underflow !== m_unf)
        $display("FAIL rand_state[%0d]: flush=%b depth=%0d ovf=%b unf=%b want %b/%0d/%b/%b", i,
                 bus.flush, bus.ras_depth, bus.ras_overflow, bus.ras_underflow,
                 (m_flush > 0), m_ras.size(), m_ovf, m_unf);
      else passed++;
    end
    reset = 1'b1;
    clear_req();
  endtask

  initial begin
    clear_req();
    bus.current = 16'h0000;
    test_reset();
    test_branch();
    test_call_ret();
    test_overflow();
    test_wrap_stall();
    test_reset_mid_flush();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
